// File: rtl/wash_plant_responder_pkg.sv
// Shared defaults and phase encodings for the wash plant responder.
// Contents:
//   DEF_* localparams - default geometry and timing of the plant model
//   phase_e           - controller phase encodings (s0..s5), shared so that
//                       benches and the controller agree on numbering
package wash_pkg;

    localparam int DEF_LEVEL_W     = 8;
    localparam int DEF_FULL_LEVEL  = 200;
    localparam int DEF_FILL_STEP   = 4;
    localparam int DEF_DRAIN_STEP  = 8;
    localparam int DEF_TMR_W       = 16;
    localparam int DEF_WASH_CYCLES = 1000;
    localparam int DEF_SPIN_CYCLES = 500;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } phase_e;

endpackage

// File: rtl/wash_plant_responder_if.sv
// Command/sensor bundle between the wash controller and the plant responder.
// Commands (controller -> plant): lock, fill_valve, motor, drain_valve, wash
// Sensors  (plant -> controller): fill, drain, cycle_timeout, spin_timeout,
//                                 level[LEVEL_W], fault
// Modports: master = controller side, slave = plant responder side.
interface wash_plant_responder_if
    import wash_pkg::*;
#(
    parameter int LEVEL_W = DEF_LEVEL_W
);

    logic               lock;
    logic               fill_valve;
    logic               motor;
    logic               drain_valve;
    logic               wash;
    logic               fill;
    logic               drain;
    logic               cycle_timeout;
    logic               spin_timeout;
    logic [LEVEL_W-1:0] level;
    logic               fault;

    modport master (
        output lock, fill_valve, motor, drain_valve, wash,
        input  fill, drain, cycle_timeout, spin_timeout, level, fault
    );

    modport slave (
        input  lock, fill_valve, motor, drain_valve, wash,
        output fill, drain, cycle_timeout, spin_timeout, level, fault
    );

endinterface

// File: rtl/wash_plant_responder_phase_timer.sv
// Saturating phase timer.
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-low reset
//   en      - count enable; low clears the count on the next edge
//   expired - high while the registered count equals LIMIT
module phase_timer #(
    parameter int TMR_W = 16,
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic expired
);

    localparam logic [TMR_W-1:0] LIM = TMR_W'(LIMIT);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt != LIM) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Decoded straight from the register so the flag appears on the same
    // edge that reaches LIMIT, with no extra pipeline stage.
    assign expired = (cnt == LIM);

endmodule

// File: rtl/wash_plant_responder.sv
// Plant-side stand-in for the washer hardware. Consumes the controller's
// actuator commands and produces the level sensor, drain sensor, wash and
// spin timeouts, plus a sticky flag for illegal command combinations.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-low reset
//   bus - wash_plant_responder_if.slave (commands in, sensors out)
module wash_plant_responder
    import wash_pkg::*;
#(
    parameter int LEVEL_W     = DEF_LEVEL_W,
    parameter int FULL_LEVEL  = DEF_FULL_LEVEL,
    parameter int FILL_STEP   = DEF_FILL_STEP,
    parameter int DRAIN_STEP  = DEF_DRAIN_STEP,
    parameter int TMR_W       = DEF_TMR_W,
    parameter int WASH_CYCLES = DEF_WASH_CYCLES,
    parameter int SPIN_CYCLES = DEF_SPIN_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    wash_plant_responder_if.slave  bus
);

    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_next;
    logic [LEVEL_W:0]   wide;
    logic               fill_q;
    logic               drain_q;
    logic               fault_q;
    logic               spin_en;
    logic               wash_expired;
    logic               spin_expired;

    // One extra bit catches the borrow on drain and the carry on fill so
    // both directions clamp instead of wrapping.
    always_comb begin
        wide = {1'b0, level_q};
        if (bus.drain_valve) begin
            wide = {1'b0, level_q} - (LEVEL_W+1)'(DRAIN_STEP);
            if (wide[LEVEL_W]) begin
                wide = '0;
            end
        end else if (bus.fill_valve) begin
            wide = {1'b0, level_q} + (LEVEL_W+1)'(FILL_STEP);
            if (wide[LEVEL_W]) begin
                wide = {1'b0, {LEVEL_W{1'b1}}};
            end
        end
        level_next = wide[LEVEL_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            level_q <= '0;
            fill_q  <= 1'b0;
            drain_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            level_q <= level_next;
            fill_q  <= (level_next >= LEVEL_W'(FULL_LEVEL));
            drain_q <= bus.drain_valve && (level_next == '0);
            if (((bus.fill_valve || bus.motor) && !bus.lock) ||
                (bus.fill_valve && bus.drain_valve)) begin
                fault_q <= 1'b1;
            end
        end
    end

    // Spin is judged on the tub already being empty, not on the level
    // this cycle's drain step is about to produce.
    assign spin_en = bus.drain_valve && bus.wash && (level_q == '0);

    phase_timer #(.TMR_W(TMR_W), .LIMIT(WASH_CYCLES)) u_wash_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.motor),
        .expired (wash_expired)
    );

    phase_timer #(.TMR_W(TMR_W), .LIMIT(SPIN_CYCLES)) u_spin_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (spin_en),
        .expired (spin_expired)
    );

    assign bus.level         = level_q;
    assign bus.fill          = fill_q;
    assign bus.drain         = drain_q;
    assign bus.fault         = fault_q;
    assign bus.cycle_timeout = wash_expired;
    assign bus.spin_timeout  = spin_expired;

endmodule

// File: tb/tb_wash_plant_responder.sv
module tb_wash_plant_responder;
    import wash_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wash_plant_responder_if #(.LEVEL_W(DEF_LEVEL_W)) bus ();

    wash_plant_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    phase_e ph = S0;

    // Behavioural plant model: integer tub level and plain run-length counts.
    int m_level = 0;
    int m_wash_run = 0;
    int m_spin_run = 0;
    bit m_fill = 0, m_drain = 0, m_fault = 0, m_valid = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s phase=%s t=%0t actual=%0d expected=%0d", nm, ph.name(), $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit spin_cond;
        if (!rst) begin
            m_level = 0; m_wash_run = 0; m_spin_run = 0;
            m_fill = 0; m_drain = 0; m_fault = 0; m_valid = 1;
        end else begin
            spin_cond = bus.drain_valve && bus.wash && (m_level == 0);
            if ((bus.fill_valve || bus.motor) && !bus.lock) m_fault = 1;
            if (bus.fill_valve && bus.drain_valve) m_fault = 1;
            if (bus.drain_valve)
                m_level = (m_level - DEF_DRAIN_STEP < 0) ? 0 : m_level - DEF_DRAIN_STEP;
            else if (bus.fill_valve)
                m_level = (m_level + DEF_FILL_STEP > 255) ? 255 : m_level + DEF_FILL_STEP;
            m_fill  = (m_level >= DEF_FULL_LEVEL);
            m_drain = bus.drain_valve && (m_level == 0);
            m_wash_run = bus.motor ? ((m_wash_run < DEF_WASH_CYCLES) ? m_wash_run + 1 : m_wash_run) : 0;
            m_spin_run = spin_cond ? ((m_spin_run < DEF_SPIN_CYCLES) ? m_spin_run + 1 : m_spin_run) : 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("level",         int'(bus.level),         m_level);
            check("fill",          int'(bus.fill),          int'(m_fill));
            check("drain",         int'(bus.drain),         int'(m_drain));
            check("cycle_timeout", int'(bus.cycle_timeout), int'(m_wash_run == DEF_WASH_CYCLES));
            check("spin_timeout",  int'(bus.spin_timeout),  int'(m_spin_run == DEF_SPIN_CYCLES));
            check("fault",         int'(bus.fault),         int'(m_fault));
        end
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmd(input bit l, input bit fv, input bit m, input bit dv, input bit w);
        bus.lock = l; bus.fill_valve = fv; bus.motor = m; bus.drain_valve = dv; bus.wash = w;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ticks(1);
        rst = 1'b1;
    endtask

    initial begin
        cmd(0, 0, 0, 0, 0);
        rst = 1'b0;
        ticks(2);
        check("rst_level", int'(bus.level), 0);
        check("rst_flags", int'({bus.fill, bus.drain, bus.cycle_timeout, bus.spin_timeout, bus.fault}), 0);
        rst = 1'b1;

        // Fill from empty
        ph = S1;
        cmd(1, 1, 0, 0, 0);
        ticks(49);
        check("fill_49_level", int'(bus.level), 196);
        check("fill_49_flag", int'(bus.fill), 0);
        ticks(1);
        check("fill_50_level", int'(bus.level), 200);
        check("fill_50_flag", int'(bus.fill), 1);
        ticks(13);
        check("fill_252", int'(bus.level), 252);
        ticks(1);
        check("fill_sat", int'(bus.level), 255);
        ticks(2);
        check("fill_sat_hold", int'(bus.level), 255);
        check("fill_no_fault", int'(bus.fault), 0);

        // Drain from 200
        ph = S2;
        cmd(0, 0, 0, 0, 0);
        do_reset();
        cmd(1, 1, 0, 0, 0);
        ticks(50);
        cmd(1, 0, 0, 1, 0);
        ticks(24);
        check("drain_24_level", int'(bus.level), 8);
        check("drain_24_flag", int'(bus.drain), 0);
        ticks(1);
        check("drain_25_level", int'(bus.level), 0);
        check("drain_25_flag", int'(bus.drain), 1);
        ticks(3);
        check("drain_hold", int'(bus.drain), 1);

        // Spin timer at empty tub
        ph = S3;
        cmd(1, 0, 0, 1, 1);
        ticks(499);
        check("spin_499", int'(bus.spin_timeout), 0);
        ticks(1);
        check("spin_500", int'(bus.spin_timeout), 1);
        ticks(4);
        check("spin_hold", int'(bus.spin_timeout), 1);
        cmd(1, 0, 0, 1, 0);
        ticks(1);
        check("spin_drop", int'(bus.spin_timeout), 0);
        cmd(1, 0, 0, 1, 1);
        ticks(300);
        cmd(1, 0, 0, 1, 0);
        ticks(1);
        cmd(1, 0, 0, 1, 1);
        ticks(499);
        check("spin_restart_499", int'(bus.spin_timeout), 0);
        ticks(1);
        check("spin_restart_500", int'(bus.spin_timeout), 1);

        // Wash timer
        ph = S4;
        cmd(1, 0, 1, 0, 0);
        ticks(999);
        check("wash_999", int'(bus.cycle_timeout), 0);
        ticks(1);
        check("wash_1000", int'(bus.cycle_timeout), 1);
        ticks(5);
        check("wash_hold", int'(bus.cycle_timeout), 1);
        cmd(1, 0, 0, 0, 0);
        ticks(1);
        check("wash_drop", int'(bus.cycle_timeout), 0);
        cmd(1, 0, 1, 0, 0);
        ticks(999);
        check("wash_restart_999", int'(bus.cycle_timeout), 0);
        ticks(1);
        check("wash_restart_1000", int'(bus.cycle_timeout), 1);

        // Faults
        ph = S5;
        cmd(0, 0, 1, 0, 0);
        ticks(1);
        check("fault_unlocked_motor", int'(bus.fault), 1);
        cmd(1, 0, 0, 0, 0);
        ticks(5);
        check("fault_sticky", int'(bus.fault), 1);
        do_reset();
        check("fault_cleared", int'(bus.fault), 0);
        cmd(1, 1, 0, 0, 0);
        ticks(10);
        check("fault_pre_level", int'(bus.level), 40);
        cmd(1, 1, 0, 1, 0);
        ticks(1);
        check("fault_both_valves", int'(bus.fault), 1);
        check("fault_drain_wins", int'(bus.level), 32);

        // Reset mid-operation
        ph = S0;
        cmd(1, 0, 0, 0, 0);
        do_reset();
        cmd(1, 1, 0, 0, 0);
        ticks(30);
        check("mid_level_120", int'(bus.level), 120);
        cmd(1, 0, 1, 0, 0);
        ticks(600);
        rst = 1'b0;
        ticks(1);
        check("mid_rst_level", int'(bus.level), 0);
        check("mid_rst_flags", int'({bus.fill, bus.drain, bus.cycle_timeout, bus.spin_timeout, bus.fault}), 0);
        rst = 1'b1;
        ticks(999);
        check("mid_wash_999", int'(bus.cycle_timeout), 0);
        ticks(1);
        check("mid_wash_1000", int'(bus.cycle_timeout), 1);

        // Randomized commands with held runs, mostly locked, rare resets
        ph = S1;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cmd(($urandom_range(0, 15) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1));
            if ($urandom_range(0, 40) == 0) rst = 1'b0;
            ticks($urandom_range(1, 12));
            rst = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/wash_plant_responder.md
Name: wash_plant_responder

Overview:
- Responder-side model of the washer hardware: it consumes the actuator commands driven by the wash controller (lock, fill_valve, motor, drain_valve, wash) and produces the sensor/timer inputs the controller consumes (fill, drain, cycle_timeout, spin_timeout).
- Tracks the water level, the wash-agitation timer and the spin timer, and flags illegal command combinations.
- Sits opposite the controller in system-level simulation and on the FPGA demo board, where it stands in for the physical sensors.

Parameters:
- LEVEL_W, 8, width of the water-level register.
- FULL_LEVEL, 200, level at or above which fill is reported.
- FILL_STEP, 4, level increment per cycle while filling.
- DRAIN_STEP, 8, level decrement per cycle while draining.
- TMR_W, 16, width of the wash and spin timers.
- WASH_CYCLES, 1000, consecutive motor-on cycles before cycle_timeout.
- SPIN_CYCLES, 500, consecutive spin-condition cycles before spin_timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- lock  in  1  door lock command
- fill_valve  in  1  inlet valve command
- motor  in  1  agitation motor command
- drain_valve  in  1  drain valve command
- wash  in  1  final-rinse or spin phase indicator from the controller
- fill  out  1  water level at or above FULL_LEVEL
- drain  out  1  drain valve open and tub empty
- cycle_timeout  out  1  wash timer expired
- spin_timeout  out  1  spin timer expired
- level  out  LEVEL_W  current water level
- fault  out  1  sticky illegal-command flag

Behaviour:
- Reset
  - rst is sampled only on the rising edge of clk; rst=0 means reset.
  - Reset clears level, both timers, fill, drain, cycle_timeout, spin_timeout and fault to 0.
  - A mid-operation reset discards the level and timer progress immediately.
- Level update (one step per cycle)
  - drain_valve=1: level_next = max(level - DRAIN_STEP, 0). Drain wins even when fill_valve=1.
  - fill_valve=1 and drain_valve=0: level_next = min(level + FILL_STEP, 2^LEVEL_W - 1). Saturates with no wrap-around.
  - Otherwise: level holds.
  - Arithmetic uses LEVEL_W+1 bits internally before clamping.
- Registered sensor outputs (updated on the same edge as level)
  - fill <= (level_next >= FULL_LEVEL).
  - drain <= drain_valve and (level_next == 0).
  - fill and drain are never both 1 when FULL_LEVEL > 0.
- Wash timer
  - While motor=1 the count increments, saturating at WASH_CYCLES.
  - While motor=0 the count clears to 0.
  - cycle_timeout = (count == WASH_CYCLES), decoded from the register. It rises after WASH_CYCLES consecutive motor-high edges.
  - cycle_timeout stays high while motor remains 1 and drops the cycle after motor falls.
  - A single motor-low cycle restarts the count.
- Spin timer
  - The spin condition is drain_valve=1, wash=1 and level==0 (the current register value).
  - Same saturate, clear and decode rules as the wash timer, with limit SPIN_CYCLES; the output is spin_timeout.
- Fault (sticky until reset)
  - Set on any cycle where (fill_valve or motor) is 1 while lock=0.
  - Also set on any cycle where fill_valve and drain_valve are both 1.
  - Fault does not alter level or timer behaviour.
- Latency
  - All outputs change one clock after the commanding input is sampled.
  - The timer outputs are a direct decode of the registered count, with no additional cycle.
- Simultaneous events
  - Timer clear beats increment when the enable drops.
  - Fault setting has no priority interaction with other logic.

Decomposition:
- Package wash_pkg:
  - default values for LEVEL_W, FULL_LEVEL, FILL_STEP, DRAIN_STEP, TMR_W, WASH_CYCLES and SPIN_CYCLES;
  - the phase encodings shared with the controller (s0–s5), for bench scoreboarding.
- Sub-module phase_timer:
  - parameters TMR_W and LIMIT; ports clk, rst, en, expired;
  - behaviour: saturating counter, clear on !en, expired = (cnt == LIMIT);
  - instantiated twice, once for wash and once for spin.

Test Plan:
- Fill: reset, then lock=1 and fill_valve=1 from level 0 -> level +4 per cycle; fill=1 on the 50th edge (level=200). level reaches 252, then saturates at 255; fault stays 0.
- Drain: from level 200, drain_valve=1 -> level −8 per cycle; drain=1 on the 25th edge with level=0. Drain stays 1 while the valve is held.
- Wash timer: lock=1, motor=1 for 1000 edges -> cycle_timeout rises exactly after edge 1000 and holds. motor=0 for one cycle -> cycle_timeout=0, and the count restarts from 0.
- Spin: level=0, drain_valve=1, wash=1 -> spin_timeout after 500 edges. Dropping wash at edge 300 clears the count, and a resumed spin needs a fresh 500 edges.
- Fault: motor=1 with lock=0 for one cycle -> fault=1 permanently. Likewise fill_valve=1 with drain_valve=1 -> fault=1, and level decrements by 8.
- Reset mid-operation: rst=0 at level 120 with the wash count at 600 -> after that edge all outputs are 0 and level=0. After release, the wash timer needs a full 1000 cycles again.
